// File: rtl/control_unit.sv
// Main decoder for the single-cycle MIPS datapath.
// Maps opcode/funct to datapath strobes and keeps a sticky illegal flag.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] RegDst,
  output logic [2:0] MemToReg,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       BranchNot,
  output logic       Jump,
  output logic       JumpReg,
  output logic       Illegal,
  output logic       IllegalSticky
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_RA  = 2'b10;
  localparam logic [2:0] WB_ALU = 3'b000;
  localparam logic [2:0] WB_MEM = 3'b001;
  localparam logic [2:0] WB_PC4 = 3'b010;
  localparam logic [2:0] WB_LUI = 3'b011;
  localparam logic [1:0] AL_ADD = 2'b00;
  localparam logic [1:0] AL_SUB = 2'b01;
  localparam logic [1:0] AL_FN  = 2'b10;
  localparam logic [1:0] AL_IMM = 2'b11;

  typedef struct packed {
    logic [1:0] regdst;
    logic [2:0] memtoreg;
    logic [1:0] aluop;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       branchnot;
    logic       jump;
    logic       jumpreg;
    logic       illegal;
  } ctrl_t;

  ctrl_t c;

  logic is_r;
  logic r_alu;
  logic r_jr;
  logic op_lw;
  logic op_sw;
  logic op_beq;
  logic op_bne;
  logic op_addi;
  logic op_imm;
  logic op_lui;
  logic op_j;
  logic op_jal;
  logic sticky_q;

  // One-hot instruction class flags; at most one is ever set.
  always_comb begin
    is_r    = (opcode == OP_R);
    r_alu   = 1'b0;
    if (is_r) begin
      case (funct)
        F_ADD, F_ADDU, F_SUB, F_SUBU,
        F_AND, F_OR, F_XOR, F_NOR,
        F_SLT, F_SLTU,
        F_SLL, F_SRL, F_SRA: r_alu = 1'b1;
        default:             r_alu = 1'b0;
      endcase
    end
    r_jr    = is_r && (funct == F_JR);
    op_lw   = (opcode == OP_LW);
    op_sw   = (opcode == OP_SW);
    op_beq  = (opcode == OP_BEQ);
    op_bne  = (opcode == OP_BNE);
    op_addi = (opcode == OP_ADDI);
    op_imm  = (opcode == OP_SLTI) || (opcode == OP_ANDI) ||
              (opcode == OP_ORI)  || (opcode == OP_XORI);
    op_lui  = (opcode == OP_LUI);
    op_j    = (opcode == OP_J);
    op_jal  = (opcode == OP_JAL);
  end

  always_comb begin
    c = '0;
    unique case (1'b1)
      r_alu: begin
        c.regdst   = RD_RD;
        c.aluop    = AL_FN;
        c.regwrite = 1'b1;
        c.memtoreg = WB_ALU;
      end
      r_jr: begin
        c.jumpreg = 1'b1;
        c.aluop   = AL_FN;
      end
      op_lw: begin
        c.alusrc   = 1'b1;
        c.memread  = 1'b1;
        c.regwrite = 1'b1;
        c.memtoreg = WB_MEM;
        c.regdst   = RD_RT;
        c.aluop    = AL_ADD;
      end
      op_sw: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
        c.aluop    = AL_ADD;
      end
      op_beq: begin
        c.branch = 1'b1;
        c.aluop  = AL_SUB;
      end
      op_bne: begin
        c.branchnot = 1'b1;
        c.aluop     = AL_SUB;
      end
      op_addi: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = AL_ADD;
      end
      op_imm: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = AL_IMM;
      end
      op_lui: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.memtoreg = WB_LUI;
        c.aluop    = AL_ADD;
      end
      op_j: begin
        c.jump = 1'b1;
      end
      op_jal: begin
        c.jump     = 1'b1;
        c.regwrite = 1'b1;
        c.regdst   = RD_RA;
        c.memtoreg = WB_PC4;
        c.aluop    = AL_ADD;
      end
      // Undecodable: every strobe stays low so nothing retires.
      default: begin
        c.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (c.illegal) begin
      sticky_q <= 1'b1;
    end
  end

  assign RegDst        = c.regdst;
  assign MemToReg      = c.memtoreg;
  assign ALUOp         = c.aluop;
  assign ALUSrc        = c.alusrc;
  assign RegWrite      = c.regwrite;
  assign MemRead       = c.memread;
  assign MemWrite      = c.memwrite;
  assign Branch        = c.branch;
  assign BranchNot     = c.branchnot;
  assign Jump          = c.jump;
  assign JumpReg       = c.jumpreg;
  assign Illegal       = c.illegal;
  assign IllegalSticky = sticky_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table-driven reference decoder,
// directed test-plan vectors, then random opcode/funct/reset mix.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [1:0] RegDst;
  logic [2:0] MemToReg;
  logic [1:0] ALUOp;
  logic       ALUSrc;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Branch;
  logic       BranchNot;
  logic       Jump;
  logic       JumpReg;
  logic       Illegal;
  logic       IllegalSticky;

  int n_vec;
  int n_bad;

  logic [15:0] op_tab [64];
  logic [5:0]  legal_ops [13];
  logic [5:0]  legal_fn [14];
  logic        ref_sticky;

  control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .RegDst        (RegDst),
    .MemToReg      (MemToReg),
    .ALUOp         (ALUOp),
    .ALUSrc        (ALUSrc),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Branch        (Branch),
    .BranchNot     (BranchNot),
    .Jump          (Jump),
    .JumpReg       (JumpReg),
    .Illegal       (Illegal),
    .IllegalSticky (IllegalSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fields: regdst, memtoreg, aluop, then
  // {alusrc,rw,mr,mw,beq,bne,j,jr,illegal}.
  function automatic logic [15:0] mk(
    logic [1:0] rd, logic [2:0] wb, logic [1:0] alu, logic [8:0] f);
    return {rd, wb, alu, f};
  endfunction

  function automatic logic [15:0] ref_ctrl(logic [5:0] op, logic [5:0] fn);
    if (op != 6'd0) return op_tab[op];
    if (fn == 6'b001000) return mk(2'b00, 3'b000, 2'b10, 9'b000000010);
    foreach (legal_fn[i])
      if (legal_fn[i] == fn && fn != 6'b001000)
        return mk(2'b01, 3'b000, 2'b10, 9'b010000000);
    return mk(2'b00, 3'b000, 2'b00, 9'b000000001);
  endfunction

  function automatic logic [15:0] dut_ctrl();
    return {RegDst, MemToReg, ALUOp, ALUSrc, RegWrite, MemRead,
            MemWrite, Branch, BranchNot, Jump, JumpReg, Illegal};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (op=%b fn=%b)",
               tag, got, exp, opcode, funct);
    end
  endtask

  // Drive one instruction for one cycle; check decode mid-cycle,
  // then the sticky flag just after the edge.
  task automatic apply(string tag, logic [5:0] op, logic [5:0] fn,
                       logic rst);
    logic [15:0] exp;
    @(negedge clk);
    opcode = op;
    funct  = fn;
    reset  = rst;
    exp    = ref_ctrl(op, fn);
    #1;
    check({tag, "/ctrl"}, 32'(dut_ctrl()), 32'(exp));
    @(posedge clk);
    ref_sticky = rst ? 1'b0 : (ref_sticky | exp[0]);
    #1;
    check({tag, "/sticky"}, 32'(IllegalSticky), 32'(ref_sticky));
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    n_vec      = 0;
    n_bad      = 0;
    ref_sticky = 1'b0;
    reset      = 1'b1;
    opcode     = 6'd0;
    funct      = 6'd0;

    foreach (op_tab[i]) op_tab[i] = mk(2'b00, 3'b000, 2'b00, 9'b000000001);
    op_tab[6'b100011] = mk(2'b00, 3'b001, 2'b00, 9'b111000000);
    op_tab[6'b101011] = mk(2'b00, 3'b000, 2'b00, 9'b100100000);
    op_tab[6'b000100] = mk(2'b00, 3'b000, 2'b01, 9'b000010000);
    op_tab[6'b000101] = mk(2'b00, 3'b000, 2'b01, 9'b000001000);
    op_tab[6'b001000] = mk(2'b00, 3'b000, 2'b00, 9'b110000000);
    op_tab[6'b001010] = mk(2'b00, 3'b000, 2'b11, 9'b110000000);
    op_tab[6'b001100] = mk(2'b00, 3'b000, 2'b11, 9'b110000000);
    op_tab[6'b001101] = mk(2'b00, 3'b000, 2'b11, 9'b110000000);
    op_tab[6'b001110] = mk(2'b00, 3'b000, 2'b11, 9'b110000000);
    op_tab[6'b001111] = mk(2'b00, 3'b011, 2'b00, 9'b110000000);
    op_tab[6'b000010] = mk(2'b00, 3'b000, 2'b00, 9'b000000100);
    op_tab[6'b000011] = mk(2'b10, 3'b010, 2'b00, 9'b010000100);

    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000101, 6'b001000, 6'b001010, 6'b001100,
                  6'b001101, 6'b001110, 6'b001111, 6'b000010,
                  6'b000011};
    legal_fn  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                  6'b100100, 6'b100101, 6'b100110, 6'b100111,
                  6'b101010, 6'b101011, 6'b000000, 6'b000010,
                  6'b000011, 6'b001000};

    apply("reset",   6'b100011, 6'b000000, 1'b1);
    apply("lw",      6'b100011, 6'b000000, 1'b0);
    apply("jal",     6'b000011, 6'b010101, 1'b0);
    apply("andi",    6'b001100, 6'b111111, 1'b0);
    apply("ori",     6'b001101, 6'b000000, 1'b0);
    apply("xori",    6'b001110, 6'b000000, 1'b0);
    apply("slti",    6'b001010, 6'b000000, 1'b0);
    apply("addi",    6'b001000, 6'b100000, 1'b0);
    apply("lui",     6'b001111, 6'b000000, 1'b0);
    apply("add",     6'b000000, 6'b100000, 1'b0);
    apply("sll",     6'b000000, 6'b000000, 1'b0);
    apply("jr",      6'b000000, 6'b001000, 1'b0);
    apply("beq",     6'b000100, 6'b000000, 1'b0);
    apply("bne",     6'b000101, 6'b000000, 1'b0);
    apply("sw",      6'b101011, 6'b000000, 1'b0);
    apply("j",       6'b000010, 6'b000000, 1'b0);
    apply("rbadfn",  6'b000000, 6'b000001, 1'b1);
    apply("ill3f",   6'b111111, 6'b000000, 1'b0);
    apply("lwhold",  6'b100011, 6'b000000, 1'b0);
    apply("rstill",  6'b111111, 6'b000000, 1'b1);
    apply("postrst", 6'b100011, 6'b000000, 1'b0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(1, 0) == 1)
        op = legal_ops[$urandom_range(12, 0)];
      else
        op = 6'($urandom);
      if (op == 6'd0 && $urandom_range(1, 0) == 1)
        fn = legal_fn[$urandom_range(13, 0)];
      else
        fn = 6'($urandom);
      apply("rand", op, fn, $urandom_range(15, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
